// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory access controller: size codes, FSM states, lane helpers.
package mem_access_ctrl_pkg;

    localparam int unsigned DATA_W             = 32;
    localparam int unsigned ADDR_W             = 32;
    localparam int unsigned RD_W               = 5;
    localparam int unsigned BE_W               = 4;
    localparam int unsigned SIZE_W             = 3;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic [SIZE_W-1:0] {
        SZ_BYTE  = 3'b000,
        SZ_UBYTE = 3'b001,
        SZ_HALF  = 3'b010,
        SZ_UHALF = 3'b011,
        SZ_WORD  = 3'b100
    } sx_size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_WB   = 2'd2
    } state_e;

    // Attributes of the access in flight, captured at accept time.
    typedef struct packed {
        logic              is_load;
        logic [SIZE_W-1:0] size;
        logic [1:0]        lane;
        logic [RD_W-1:0]   rd;
    } access_t;

    function automatic logic is_aligned(input logic [SIZE_W-1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE, SZ_UBYTE: return 1'b1;
            SZ_HALF, SZ_UHALF: return !lane[0];
            default:           return lane == 2'b00;
        endcase
    endfunction

    function automatic logic [BE_W-1:0] byte_en(input logic [SIZE_W-1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE, SZ_UBYTE: return 4'b0001 << lane;
            SZ_HALF, SZ_UHALF: return 4'b0011 << lane;
            default:           return 4'b1111;
        endcase
    endfunction

    // Store data is replicated so every candidate lane already carries it.
    function automatic logic [DATA_W-1:0] replicate(input logic [SIZE_W-1:0] size, input logic [DATA_W-1:0] d);
        case (size)
            SZ_BYTE, SZ_UBYTE: return {4{d[7:0]}};
            SZ_HALF, SZ_UHALF: return {2{d[15:0]}};
            default:           return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load formatter: picks the addressed byte/half lane and sign- or zero-extends it.
module lsu_load_fmt
    import mem_access_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        lane,
    input  logic [SIZE_W-1:0] size,
    output logic [DATA_W-1:0] data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        data_c = rdata;
        case (size)
            SZ_BYTE:  data_c = {{24{byte_sel[7]}}, byte_sel};
            SZ_UBYTE: data_c = {24'd0, byte_sel};
            SZ_HALF:  data_c = {{16{half_sel[15]}}, half_sel};
            SZ_UHALF: data_c = {16'd0, half_sel};
            default:  data_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store bus sequencer: IDLE -> BUSY -> (WB for loads), with lane steering and stall.
// Define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES cycles without mem_ack.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
`endif
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_o,
    input  logic              mem_we,
    input  logic [SIZE_W-1:0] sx_size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RD_W-1:0]   rd,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              delayed_load,
    output logic [RD_W-1:0]   delayed_rd,
    output logic [DATA_W-1:0] load_data,
    output logic              misalign,
    output logic              bus_err
);

    state_e             state;
    access_t            acc_q;
    logic               access_c;
    logic               aligned_c;
    logic               accept_c;
    logic [DATA_W-1:0]  fmt_data_c;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] busy_cnt;
`endif

    // Request decode; a simultaneous load+store is handled as a store.
    always_comb begin
        access_c  = load_o | mem_we;
        aligned_c = is_aligned(sx_size, addr[1:0]);
        accept_c  = (state == S_IDLE) && access_c && aligned_c;
        misalign  = (state == S_IDLE) && access_c && !aligned_c;
        stall     = accept_c || (state == S_BUSY) || (state == S_WB);
    end

    lsu_load_fmt u_load_fmt (
        .rdata  (mem_rdata),
        .lane   (acc_q.lane),
        .size   (acc_q.size),
        .data_c (fmt_data_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            acc_q        <= '0;
            mem_req      <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            delayed_load <= 1'b0;
            delayed_rd   <= '0;
            load_data    <= '0;
            bus_err      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            busy_cnt     <= '0;
`endif
        end else begin
            delayed_load <= 1'b0;
            delayed_rd   <= '0;
            bus_err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        state         <= S_BUSY;
                        mem_req       <= 1'b1;
                        mem_wr        <= mem_we;
                        mem_addr      <= {addr[ADDR_W-1:2], 2'b00};
                        mem_be        <= byte_en(sx_size, addr[1:0]);
                        mem_wdata     <= replicate(sx_size, wdata);
                        acc_q.is_load <= !mem_we;
                        acc_q.size    <= sx_size;
                        acc_q.lane    <= addr[1:0];
                        acc_q.rd      <= rd;
`ifdef MEM_TIMEOUT_EN
                        busy_cnt      <= '0;
`endif
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_wr  <= 1'b0;
                        if (acc_q.is_load) begin
                            load_data    <= fmt_data_c;
                            delayed_load <= 1'b1;
                            delayed_rd   <= acc_q.rd;
                            state        <= S_WB;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_req <= 1'b0;
                        mem_wr  <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        busy_cnt <= busy_cnt + CNT_W'(1);
                    end
`endif
                end
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, corner sequences, random vs model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_o = 1'b0;
    logic        mem_we = 1'b0;
    logic [2:0]  sx_size = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        stall;
    logic        delayed_load;
    logic [4:0]  delayed_rd;
    logic [31:0] load_data;
    logic        misalign;
    logic        bus_err;

    mem_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .load_o       (load_o),
        .mem_we       (mem_we),
        .sx_size      (sx_size),
        .addr         (addr),
        .wdata        (wdata),
        .rd           (rd),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .stall        (stall),
        .delayed_load (delayed_load),
        .delayed_rd   (delayed_rd),
        .load_data    (load_data),
        .misalign     (misalign),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          lat;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_ld;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_ld = 32'd0;
    vec_t        vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte-count arithmetic on address and data, independent of lane muxes.
    function automatic vec_t model(input vec_t v);
        int          n;
        int          lane;
        logic [31:0] mask;
        logic [31:0] val;
        logic [31:0] t;
        n    = (v.size <= 3'd1) ? 1 : (v.size <= 3'd3) ? 2 : 4;
        lane = int'(v.addr % 4);
        v.exp_mis = (v.addr % n) != 0;
        t = ((32'd1 << n) - 32'd1) << lane;
        v.exp_be = (n == 4) ? 4'hF : t[3:0];
        for (int k = 0; k < 4; k++) v.exp_wd[8*k +: 8] = v.wdata[8*(k % n) +: 8];
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
        val  = (v.rdata >> (8*lane)) & mask;
        if (n < 4 && (v.size == 3'd0 || v.size == 3'd2) && val[8*n-1]) val = val | ~mask;
        v.exp_ld = val;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        int   n_stall;
        logic is_ld;
        is_ld = v.ld & ~v.st;
        @(negedge clk);
        load_o = v.ld; mem_we = v.st; sx_size = v.size; addr = v.addr;
        wdata = v.wdata; rd = v.rd; mem_ack = 1'b0;
        #1;
        chk("misalign", misalign, v.exp_mis);
        chk("stall_accept", stall, !v.exp_mis);
        if (v.exp_mis) begin
            @(negedge clk); load_o = 1'b0; mem_we = 1'b0;
            #1;
            chk("mis_req", mem_req, 1'b0);
            chk("mis_dl", delayed_load, 1'b0);
            chk("mis_ldata", load_data, last_ld);
        end else begin
            n_stall = 1;
            @(negedge clk); load_o = 1'b0; mem_we = 1'b0;
            #1;
            chk("req", mem_req, 1'b1);
            chk("wr", mem_wr, !is_ld);
            chk("maddr", mem_addr, {v.addr[31:2], 2'b00});
            chk("be", mem_be, v.exp_be);
            if (!is_ld) chk("wdata", mem_wdata, v.exp_wd);
            for (int i = 0; i < v.lat; i++) begin
                if (i > 0) begin @(negedge clk); #1; end
                chk("req_hold", mem_req, 1'b1);
                if (stall) n_stall++;
                mem_ack   = (i == v.lat - 1);
                mem_rdata = (i == v.lat - 1) ? v.rdata : 32'($urandom);
            end
            @(negedge clk); mem_ack = 1'b0;
            #1;
            if (stall) n_stall++;
            chk("req_drop", mem_req, 1'b0);
            if (is_ld) begin
                chk("wb_dl", delayed_load, 1'b1);
                chk("wb_rd", delayed_rd, v.rd);
                chk("wb_data", load_data, v.exp_ld);
                last_ld = v.exp_ld;
                @(negedge clk); #1;
                if (stall) n_stall++;
            end
            chk("end_dl", delayed_load, 1'b0);
            chk("end_ldata", load_data, last_ld);
            chk("end_err", bus_err, 1'b0);
            chk("stall_cycles", n_stall, 1 + v.lat + (is_ld ? 1 : 0));
        end
    endtask

    initial begin
        int busy;
        // Reset values
        #3;
        chk("rst_req", mem_req, 1'b0);
        chk("rst_wr", mem_wr, 1'b0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_be", mem_be, 4'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_dl", delayed_load, 1'b0);
        chk("rst_drd", delayed_rd, 5'd0);
        chk("rst_ldata", load_data, 32'd0);
        chk("rst_mis", misalign, 1'b0);
        chk("rst_err", bus_err, 1'b0);
        chk("rst_stall", stall, 1'b0);
        @(negedge clk); @(negedge clk); rst = 1'b1;

        // ld st size addr wdata rdata rd lat | mis be wd ld
        vq.push_back('{1'b1, 1'b0, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 5'd3,  1, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80});
        vq.push_back('{1'b0, 1'b1, 3'd2, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 5'd0,  4, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0});
        vq.push_back('{1'b1, 1'b0, 3'd4, 32'h0000_3001, 32'h0, 32'h0, 5'd1,          1, 1'b1, 4'b0000, 32'h0,         32'h0});
        vq.push_back('{1'b1, 1'b0, 3'd3, 32'h0000_4002, 32'h0, 32'hBEEF_0000, 5'd9,  2, 1'b0, 4'b1100, 32'h0,         32'h0000_BEEF});
        vq.push_back('{1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'h0, 32'h1234_8001, 5'd17, 2, 1'b0, 4'b0011, 32'h0,         32'hFFFF_8001});
        vq.push_back('{1'b1, 1'b0, 3'd1, 32'h0000_0021, 32'h0, 32'h0000_F000, 5'd31, 1, 1'b0, 4'b0010, 32'h0,         32'h0000_00F0});
        vq.push_back('{1'b0, 1'b1, 3'd4, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 5'd0,  1, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0});
        vq.push_back('{1'b0, 1'b1, 3'd0, 32'h0000_0005, 32'h1234_56AB, 32'h0, 5'd0,  3, 1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0});
        vq.push_back('{1'b0, 1'b1, 3'd2, 32'h0000_0041, 32'h0, 32'h0, 5'd0,          1, 1'b1, 4'b0000, 32'h0,         32'h0});
        vq.push_back('{1'b1, 1'b0, 3'd4, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 5'd0,  1, 1'b0, 4'b1111, 32'h0,         32'hCAFE_F00D});
        vq.push_back('{1'b1, 1'b1, 3'd0, 32'h0000_0002, 32'h0000_0077, 32'hFFFF_FFFF, 5'd4, 1, 1'b0, 4'b0100, 32'h7777_7777, 32'h0});
        vq.push_back('{1'b1, 1'b0, 3'd2, 32'h0000_0006, 32'h0, 32'h7FFF_0000, 5'd12, 3, 1'b0, 4'b1100, 32'h0,         32'h0000_7FFF});
        vq.push_back('{1'b1, 1'b0, 3'd4, 32'h0000_3002, 32'h0, 32'h0, 5'd2,          1, 1'b1, 4'b0000, 32'h0,         32'h0});
        foreach (vq[i]) apply(vq[i]);

        // Reset during BUSY drops the request at once; a late ack must not cause writeback
        @(negedge clk);
        load_o = 1'b1; mem_we = 1'b0; sx_size = 3'd4; addr = 32'h80; rd = 5'd5;
        @(negedge clk); load_o = 1'b0;
        #1 chk("rb_req_before", mem_req, 1'b1);
        rst = 1'b0;
        #1;
        chk("rb_req_async", mem_req, 1'b0);
        chk("rb_stall", stall, 1'b0);
        chk("rb_ldata", load_data, 32'd0);
        last_ld = 32'd0;
        @(negedge clk); rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk); mem_ack = 1'b0;
        #1;
        chk("rb_no_wb", delayed_load, 1'b0);
        chk("rb_ldata_after", load_data, 32'd0);
        chk("rb_idle", stall, 1'b0);

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after 16 BUSY cycles with a one-cycle bus_err
        @(negedge clk);
        load_o = 1'b1; mem_we = 1'b0; sx_size = 3'd4; addr = 32'h300; rd = 5'd6;
        @(negedge clk); load_o = 1'b0;
        busy = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!mem_req) break;
            busy++;
            @(negedge clk);
        end
        chk("to_busy_cycles", busy, 16);
        chk("to_err", bus_err, 1'b1);
        chk("to_no_wb", delayed_load, 1'b0);
        chk("to_stall", stall, 1'b0);
        @(negedge clk); #1;
        chk("to_err_pulse", bus_err, 1'b0);
        chk("to_no_wb2", delayed_load, 1'b0);
`else
        // No ack: BUSY is held indefinitely without error
        @(negedge clk);
        mem_we = 1'b1; sx_size = 3'd4; addr = 32'h200; wdata = 32'h5555_AAAA;
        @(negedge clk); mem_we = 1'b0;
        busy = 0;
        repeat (40) @(negedge clk);
        #1;
        chk("hold_req", mem_req, 1'b1);
        chk("hold_err", bus_err, 1'b0);
        chk("hold_stall", stall, 1'b1);
        mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        #1;
        chk("hold_done_req", mem_req, 1'b0);
        chk("hold_done_stall", stall, 1'b0);
        chk("hold_busy_unused", busy, 0);
`endif

        // Random accesses checked against the model
        for (int i = 0; i < 60; i++) begin
            vec_t v;
            v.size  = 3'($urandom_range(0, 4));
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.rd    = 5'($urandom);
            case ($urandom_range(0, 2))
                0:       begin v.ld = 1'b1; v.st = 1'b0; end
                1:       begin v.ld = 1'b0; v.st = 1'b1; end
                default: begin v.ld = 1'b1; v.st = 1'b1; end
            endcase
            v.lat = int'($urandom_range(1, 4));
            v = model(v);
            apply(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
